pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised fetch-stage program counter: holds the current fetch address,
//  advances by a fixed step, honours stall, and accepts prioritised redirects
//  (exception, resolved branch/jump, return). Includes a small circular
//  return-address stack (RAS) so call/return targets are produced in fetch.
//  Sits between the hazard unit / EX branch resolution and instruction memory.
// PARAMETERS
//  ADDR_W     32            address width in bits
//  RESET_VEC  32'h0000_0000 PC value loaded on Reset (ADDR_W bits)
//  EXC_VEC    32'h0000_0100 exception handler entry address
//  STEP       4             sequential increment per fetch
//  RAS_DEPTH  4             RAS entries (power of two, >=2)
// PORTS
//  CLK              in   1       clock, rising edge
//  Reset            in   1       asynchronous, active-high reset
//  PCWrite          in   1       1 = PC may advance; 0 = stall (hold)
//  Exc              in   1       exception redirect to EXC_VEC
//  Redirect_Valid   in   1       resolved branch/jump redirect
//  Redirect_Target  in   ADDR_W  target for Redirect_Valid
//  Call             in   1       current fetch is a call: push PC+STEP
//  Ret              in   1       current fetch is a return: pop target
//  currentAddress   out  ADDR_W  registered fetch address
//  RAS_Empty        out  1       RAS count == 0
//  RAS_Full         out  1       RAS count == RAS_DEPTH
//  RAS_Underflow    out  1       1-cycle pulse: Ret accepted with RAS empty
// BEHAVIOUR
//  - Reset (async): currentAddress=RESET_VEC, RAS count=0, top ptr=0,
//    RAS_Empty=1, RAS_Full=0, RAS_Underflow=0. RAS entry contents don't-care.
//  - All state updates on rising CLK; currentAddress changes 1 cycle after
//    the controlling inputs are sampled. Flags are derived from count (comb).
//  - Next-PC priority, highest first:
//    1 Exc            -> EXC_VEC; RAS cleared (count=0); Call/Ret ignored
//    2 Redirect_Valid -> Redirect_Target; Call/Ret ignored; RAS unchanged
//    3 PCWrite=0      -> hold PC; Call/Ret ignored; RAS unchanged
//    4 Ret, RAS non-empty -> top entry; pop (count-1)
//    5 Ret, RAS empty -> PC+STEP; RAS_Underflow=1 next cycle
//    6 otherwise      -> PC+STEP
//  - Exc and Redirect_Valid override stall (they flush the front end).
//  - Call (accepted only at priority 4-6): push currentAddress+STEP.
//    RAS full: circular overwrite of oldest entry, count stays RAS_DEPTH.
//  - Call and Ret same cycle: next PC = old top (or PC+STEP if empty); the
//    top slot is then replaced by currentAddress+STEP; count unchanged
//    (empty: count becomes 1, RAS_Underflow still pulses).
//  - Arithmetic: PC+STEP is modulo 2^ADDR_W (wraps silently, no flag).
//  - Reset asserted mid-operation overrides everything immediately.
// TESTING
//  - Reset, PCWrite=1 for 3 cycles -> currentAddress 0,4,8,12 (defaults).
//  - PC=0x10, PCWrite=0 two cycles then Redirect_Valid, target 0x80, same
//    stall -> PC holds 0x10, then 0x80 (redirect beats stall).
//  - PC=0x20 Call, PC=0x80 Call, then Ret twice -> next PCs 0x84 then 0x24;
//    RAS_Empty=1 after second Ret; third Ret -> PC+4, RAS_Underflow pulse 1 cyc.
//  - 5 Calls at RAS_DEPTH=4 from 0x0,0x4,..0x10 -> RAS_Full=1; 4 Rets return
//    0x14,0x10,0x0C,0x08 (oldest 0x04 lost), then RAS_Empty=1.
//  - Exc with Redirect_Valid and Ret same cycle, RAS count 2 -> PC=EXC_VEC,
//    RAS_Empty=1; PC=32'hFFFF_FFFC, PCWrite=1 -> PC=0 (wrap).

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with prioritised redirects and a small
// circular return-address stack (RAS) for call/return prediction.
module pc_sequencer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0000_0100,
    parameter int unsigned       STEP      = 4,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              PCWrite,
    input  logic              Exc,
    input  logic              Redirect_Valid,
    input  logic [ADDR_W-1:0] Redirect_Target,
    input  logic              Call,
    input  logic              Ret,
    output logic [ADDR_W-1:0] currentAddress,
    output logic              RAS_Empty,
    output logic              RAS_Full,
    output logic              RAS_Underflow
);

    localparam int unsigned       PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned       CNT_W   = $clog2(RAS_DEPTH + 1);
    localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0]  top, top_next;
    logic [CNT_W-1:0]  count, count_next;
    logic [ADDR_W-1:0] pc_next, seq_pc;
    logic              underflow_next;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;

    assign seq_pc    = currentAddress + STEP_V;
    assign RAS_Empty = (count == '0);
    assign RAS_Full  = (count == DEPTH_C);

    // Next-PC selection and RAS push/pop decisions, in priority order.
    always_comb begin
        pc_next        = currentAddress;
        top_next       = top;
        count_next     = count;
        underflow_next = 1'b0;
        wr_en          = 1'b0;
        wr_idx         = top;
        if (Exc) begin
            pc_next    = EXC_VEC;
            count_next = '0;
        end else if (Redirect_Valid) begin
            pc_next = Redirect_Target;
        end else if (PCWrite) begin
            pc_next = seq_pc;
            if (Ret && (count != '0)) begin
                pc_next = ras[top];
                // Call+Ret on a non-empty stack replaces the top slot in place
                // rather than popping and pushing through the pointer.
                if (Call) begin
                    wr_en  = 1'b1;
                    wr_idx = top;
                end else begin
                    top_next   = top - PTR_ONE;
                    count_next = count - CNT_ONE;
                end
            end else begin
                underflow_next = Ret;
                if (Call) begin
                    // Pointer wraps, so a push when full overwrites the oldest entry.
                    wr_en    = 1'b1;
                    wr_idx   = top + PTR_ONE;
                    top_next = top + PTR_ONE;
                    if (count != DEPTH_C)
                        count_next = count + CNT_ONE;
                end
            end
        end
    end

    // PC, stack pointer, occupancy and underflow pulse registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            currentAddress <= RESET_VEC;
            top            <= '0;
            count          <= '0;
            RAS_Underflow  <= 1'b0;
        end else begin
            currentAddress <= pc_next;
            top            <= top_next;
            count          <= count_next;
            RAS_Underflow  <= underflow_next;
        end
    end

    // RAS storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge CLK) begin
        if (wr_en)
            ras[wr_idx] <= seq_pc;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with default parameters.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        PCWrite;
    logic        Exc;
    logic        Redirect_Valid;
    logic [31:0] Redirect_Target;
    logic        Call;
    logic        Ret;
    logic [31:0] currentAddress;
    logic        RAS_Empty;
    logic        RAS_Full;
    logic        RAS_Underflow;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    pc_sequencer #(
        .ADDR_W   (32),
        .RESET_VEC(32'h0000_0000),
        .EXC_VEC  (32'h0000_0100),
        .STEP     (4),
        .RAS_DEPTH(4)
    ) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .PCWrite        (PCWrite),
        .Exc            (Exc),
        .Redirect_Valid (Redirect_Valid),
        .Redirect_Target(Redirect_Target),
        .Call           (Call),
        .Ret            (Ret),
        .currentAddress (currentAddress),
        .RAS_Empty      (RAS_Empty),
        .RAS_Full       (RAS_Full),
        .RAS_Underflow  (RAS_Underflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        PCWrite = 1'b1; Exc = 1'b0; Redirect_Valid = 1'b0;
        Redirect_Target = '0; Call = 1'b0; Ret = 1'b0;
    endtask

    task automatic jump(input logic [31:0] target);
        idle();
        Redirect_Valid  = 1'b1;
        Redirect_Target = target;
        step();
        idle();
        check("jump", currentAddress, target);
    endtask

    initial begin
        idle();
        PCWrite = 1'b0;
        Reset   = 1'b1;
        step();
        step();
        check("rst_pc", currentAddress, 32'h0);
        check("rst_empty", 32'(RAS_Empty), 32'd1);
        check("rst_full", 32'(RAS_Full), 32'd0);
        check("rst_uf", 32'(RAS_Underflow), 32'd0);

        // Sequential advance
        Reset = 1'b0;
        idle();
        step(); check("seq1", currentAddress, 32'h4);
        step(); check("seq2", currentAddress, 32'h8);
        step(); check("seq3", currentAddress, 32'hC);

        // Stall then redirect during stall
        jump(32'h10);
        PCWrite = 1'b0;
        step(); check("stall1", currentAddress, 32'h10);
        step(); check("stall2", currentAddress, 32'h10);
        Redirect_Valid = 1'b1; Redirect_Target = 32'h80;
        step(); check("redir_stall", currentAddress, 32'h80);

        // Call/return pairs and underflow
        jump(32'h20);
        Call = 1'b1;
        step(); check("call1_pc", currentAddress, 32'h24);
        check("call1_nonempty", 32'(RAS_Empty), 32'd0);
        jump(32'h80);
        Call = 1'b1;
        step(); check("call2_pc", currentAddress, 32'h84);
        Call = 1'b0; Ret = 1'b1;
        step(); check("ret1_pc", currentAddress, 32'h84);
        step(); check("ret2_pc", currentAddress, 32'h24);
        check("ret2_empty", 32'(RAS_Empty), 32'd1);
        check("ret2_uf", 32'(RAS_Underflow), 32'd0);
        step(); check("ret3_pc", currentAddress, 32'h28);
        check("ret3_uf", 32'(RAS_Underflow), 32'd1);
        Ret = 1'b0;
        step(); check("uf_pulse_end", 32'(RAS_Underflow), 32'd0);
        check("after_uf_pc", currentAddress, 32'h2C);

        // Overflow: five calls into a four-entry stack
        jump(32'h0);
        Call = 1'b1;
        step(); check("ovf_c1", currentAddress, 32'h4);
        step(); step(); step();
        check("ovf_c4_full", 32'(RAS_Full), 32'd1);
        step(); check("ovf_c5_pc", currentAddress, 32'h14);
        check("ovf_c5_full", 32'(RAS_Full), 32'd1);
        Call = 1'b0; Ret = 1'b1;
        step(); check("ovf_r1", currentAddress, 32'h14);
        check("ovf_r1_notfull", 32'(RAS_Full), 32'd0);
        step(); check("ovf_r2", currentAddress, 32'h10);
        step(); check("ovf_r3", currentAddress, 32'hC);
        step(); check("ovf_r4", currentAddress, 32'h8);
        check("ovf_empty", 32'(RAS_Empty), 32'd1);
        check("ovf_no_uf", 32'(RAS_Underflow), 32'd0);
        Ret = 1'b0;

        // Call and Ret in the same cycle
        jump(32'h50);
        Call = 1'b1;
        step(); check("cr_push", currentAddress, 32'h54);
        Ret = 1'b1;
        step(); check("cr_pc", currentAddress, 32'h54);
        check("cr_uf", 32'(RAS_Underflow), 32'd0);
        Call = 1'b0;
        step(); check("cr_pop", currentAddress, 32'h58);
        check("cr_pop_empty", 32'(RAS_Empty), 32'd1);
        Call = 1'b1;
        step(); check("cr_empty_pc", currentAddress, 32'h5C);
        check("cr_empty_uf", 32'(RAS_Underflow), 32'd1);
        check("cr_empty_cnt1", 32'(RAS_Empty), 32'd0);
        Call = 1'b0;
        step(); check("cr_empty_pop", currentAddress, 32'h5C);
        check("cr_empty_pop_empty", 32'(RAS_Empty), 32'd1);
        Ret = 1'b0;

        // Exception beats redirect and return, clears RAS
        jump(32'h40);
        Call = 1'b1;
        step(); step();
        check("exc_pre_pc", currentAddress, 32'h48);
        Call = 1'b0; Exc = 1'b1; Redirect_Valid = 1'b1;
        Redirect_Target = 32'h200; Ret = 1'b1;
        step(); check("exc_pc", currentAddress, 32'h100);
        check("exc_empty", 32'(RAS_Empty), 32'd1);
        check("exc_uf", 32'(RAS_Underflow), 32'd0);

        // Exception overrides stall
        idle(); PCWrite = 1'b0; Exc = 1'b1;
        step(); check("exc_stall", currentAddress, 32'h100);

        // Address wrap
        jump(32'hFFFF_FFFC);
        step(); check("wrap", currentAddress, 32'h0);

        // Asynchronous reset mid-operation
        step(); step();
        #2 Reset = 1'b1;
        #1 check("async_rst_pc", currentAddress, 32'h0);
        @(negedge CLK);
        Reset = 1'b0;
        step(); check("post_rst", currentAddress, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
